// File: rtl/vga_char_render_if.sv
// Per-pixel bundle between the text components, the font ROM and the renderer.
// The master drives beam/character info and serves the ROM; the slave is the renderer.
interface vga_char_render_if;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        hsync_in;
   logic        vsync_in;
   logic        de_in;
   logic [7:0]  char_in;
   logic        h2a;
   logic [2:0]  color_in;
   logic [1:0]  zoom_in;
   logic        blink_in;
   logic [10:0] font_addr;
   logic [7:0]  font_data;
   logic [2:0]  rgb;
   logic        hsync;
   logic        vsync;
   logic        de;

   modport master (
      output x, y, hsync_in, vsync_in, de_in, char_in, h2a, color_in, zoom_in, blink_in,
      output font_data,
      input  font_addr, rgb, hsync, vsync, de
   );

   modport slave (
      input  x, y, hsync_in, vsync_in, de_in, char_in, h2a, color_in, zoom_in, blink_in,
      input  font_data,
      output font_addr, rgb, hsync, vsync, de
   );
endinterface

// File: rtl/vga_char_render.sv
// Character pixel stage: hex->ASCII, font ROM row fetch, pixel select, blink and
// sync/DE delay. Beam position to rgb is 3 px_clk cycles.
`ifndef BLACK
`define BLACK 3'b000
`endif

module vga_char_render #(
   parameter logic [2:0]  BG_COLOR     = `BLACK,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input logic              px_clk,
   input logic              reset,
   vga_char_render_if.slave bus
);

   localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

   // Stage A: beam position and timing
   logic [9:0] x_a, y_a;
   logic       hs_a, vs_a, de_a;

   // Stage B: ROM address plus the attributes that travel with it
   logic [10:0] font_addr_q;
   logic [2:0]  col_b, color_b;
   logic        blink_b, hs_b, vs_b, de_b;

   // Stage C: aligned with the ROM's registered output
   logic [2:0]  col_c, color_c;
   logic        blink_c, hs_c, vs_c, de_c;

   logic        vs_prev, blink_off;
   logic [7:0]  frame_cnt;

   logic [3:0]  nib;
   logic [7:0]  ascii;
   logic [9:0]  x_zoom, y_zoom;
   logic        pix, vsync_rise;
   logic [2:0]  rgb_c;

   always_comb begin
      nib = bus.char_in[3:0];
      if (bus.h2a) begin
         ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
      end else begin
         ascii = bus.char_in;
      end
      x_zoom     = x_a >> bus.zoom_in;
      y_zoom     = y_a >> bus.zoom_in;
      vsync_rise = bus.vsync_in && !vs_prev;
      pix        = bus.font_data[3'd7 - col_c];
   end

   always_ff @(posedge px_clk or posedge reset) begin
      if (reset) begin
         x_a         <= '0;
         y_a         <= '0;
         hs_a        <= 1'b0;
         vs_a        <= 1'b0;
         de_a        <= 1'b0;
         font_addr_q <= '0;
         col_b       <= '0;
         color_b     <= '0;
         blink_b     <= 1'b0;
         hs_b        <= 1'b0;
         vs_b        <= 1'b0;
         de_b        <= 1'b0;
         col_c       <= '0;
         color_c     <= '0;
         blink_c     <= 1'b0;
         hs_c        <= 1'b0;
         vs_c        <= 1'b0;
         de_c        <= 1'b0;
      end else begin
         x_a         <= bus.x;
         y_a         <= bus.y;
         hs_a        <= bus.hsync_in;
         vs_a        <= bus.vsync_in;
         de_a        <= bus.de_in;
         font_addr_q <= {ascii, y_zoom[2:0]};
         col_b       <= x_zoom[2:0];
         color_b     <= bus.color_in;
         blink_b     <= bus.blink_in;
         hs_b        <= hs_a;
         vs_b        <= vs_a;
         de_b        <= de_a;
         col_c       <= col_b;
         color_c     <= color_b;
         blink_c     <= blink_b;
         hs_c        <= hs_b;
         vs_c        <= vs_b;
         de_c        <= de_b;
      end
   end

   // A vsync edge that also wraps the counter is one event: one toggle.
   always_ff @(posedge px_clk or posedge reset) begin
      if (reset) begin
         vs_prev   <= 1'b0;
         frame_cnt <= '0;
         blink_off <= 1'b0;
      end else begin
         vs_prev <= bus.vsync_in;
         if (vsync_rise) begin
            if (frame_cnt == LAST_FRAME) begin
               frame_cnt <= '0;
               blink_off <= ~blink_off;
            end else begin
               frame_cnt <= frame_cnt + 8'd1;
            end
         end
      end
   end

   // rgb is formed from the ROM's registered row; de_c gating forces 0 under reset.
   always_comb begin
      if (!de_c) begin
         rgb_c = 3'b000;
      end else if (color_c == `BLACK || !pix || (blink_c && blink_off)) begin
         rgb_c = BG_COLOR;
      end else begin
         rgb_c = color_c;
      end
   end

   assign bus.font_addr = font_addr_q;
   assign bus.rgb       = rgb_c;
   assign bus.hsync     = hs_c;
   assign bus.vsync     = vs_c;
   assign bus.de        = de_c;

endmodule

// File: tb/tb_vga_char_render.sv
// Directed bench for vga_char_render with a synchronous font ROM model.
module tb_vga_char_render;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] WHITE = 3'b111;
   localparam logic [2:0] BG    = 3'b001;

   logic px_clk = 1'b0;
   logic reset  = 1'b1;
   logic [7:0] rom_char = 8'h00;
   logic [7:0] rom_pat  = 8'h00;
   int total = 0;
   int bad   = 0;

   vga_char_render_if vif ();

   vga_char_render #(
      .BG_COLOR     (BG),
      .BLINK_FRAMES (2)
   ) dut (
      .px_clk (px_clk),
      .reset  (reset),
      .bus    (vif.slave)
   );

   always #5 px_clk = ~px_clk;

   // ROM only returns the pattern for the glyph under test, so a wrong code shows up.
   always @(posedge px_clk) begin
      vif.font_data <= (vif.font_addr[10:3] == rom_char) ? rom_pat : 8'h00;
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge px_clk);
         #1;
      end
   endtask

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial begin
      vif.x = '0;
      vif.y = '0;
      vif.hsync_in = 1'b0;
      vif.vsync_in = 1'b0;
      vif.de_in = 1'b0;
      vif.char_in = '0;
      vif.h2a = 1'b0;
      vif.color_in = BLACK;
      vif.zoom_in = '0;
      vif.blink_in = 1'b0;

      // Reset state
      tick(3);
      check_eq("rst_rgb", 16'(vif.rgb), 16'h0);
      check_eq("rst_hsync", 16'(vif.hsync), 16'h0);
      check_eq("rst_vsync", 16'(vif.vsync), 16'h0);
      check_eq("rst_de", 16'(vif.de), 16'h0);
      check_eq("rst_addr", 16'(vif.font_addr), 16'h0);
      reset = 1'b0;
      tick(2);

      // Hex translation (y=0, zoom 0 so row bits are 0)
      vif.h2a = 1'b1;
      vif.char_in = 8'h00; tick(1); check_eq("h2a_0", 16'(vif.font_addr), {5'd0, 8'h30, 3'd0});
      vif.char_in = 8'h09; tick(1); check_eq("h2a_9", 16'(vif.font_addr), {5'd0, 8'h39, 3'd0});
      vif.char_in = 8'h0A; tick(1); check_eq("h2a_A", 16'(vif.font_addr), {5'd0, 8'h41, 3'd0});
      vif.char_in = 8'h0F; tick(1); check_eq("h2a_F", 16'(vif.font_addr), {5'd0, 8'h46, 3'd0});
      vif.char_in = 8'hCA; tick(1); check_eq("h2a_hi", 16'(vif.font_addr), {5'd0, 8'h41, 3'd0});
      vif.h2a = 1'b0;
      vif.char_in = 8'h5A; tick(1); check_eq("raw_5A", 16'(vif.font_addr), {5'd0, 8'h5A, 3'd0});

      // Latency and alignment: one-pixel de/hsync pulse at x=100
      vif.char_in = 8'h41;
      rom_char = 8'h41;
      rom_pat = 8'hFF;
      vif.color_in = WHITE;
      vif.x = 10'd100;
      tick(4);
      vif.de_in = 1'b1;
      vif.hsync_in = 1'b1;
      tick(1);
      vif.de_in = 1'b0;
      vif.hsync_in = 1'b0;
      check_eq("lat_de1", 16'(vif.de), 16'h0);
      tick(1);
      check_eq("lat_de2", 16'(vif.de), 16'h0);
      check_eq("lat_rgb2", 16'(vif.rgb), 16'h0);
      tick(1);
      check_eq("lat_de3", 16'(vif.de), 16'h1);
      check_eq("lat_hs3", 16'(vif.hsync), 16'h1);
      check_eq("lat_rgb3", 16'(vif.rgb), 16'(WHITE));
      tick(1);
      check_eq("lat_de4", 16'(vif.de), 16'h0);
      check_eq("lat_rgb4", 16'(vif.rgb), 16'h0);

      // Zoom: row index from y>>1, pixel sweep across a 16-wide cell
      vif.zoom_in = 2'd1;
      vif.y = 10'd5;
      vif.x = 10'd0;
      tick(2);
      check_eq("zoom_row", 16'(vif.font_addr[2:0]), 16'd2);
      rom_pat = 8'b1000_0000;
      vif.de_in = 1'b1;
      tick(3);
      for (int i = 0; i < 18; i++) begin
         vif.x = 10'(i);
         tick(1);
         if (i >= 2) begin
            check_eq($sformatf("zoom_x%0d", i - 2), 16'(vif.rgb),
                     16'((i - 2 < 2) ? WHITE : BG));
         end
      end
      vif.zoom_in = 2'd0;
      vif.x = 10'd0;
      vif.y = 10'd0;

      // Inactive colour and blanking
      rom_pat = 8'hFF;
      vif.color_in = BLACK;
      tick(4);
      check_eq("black_bg", 16'(vif.rgb), 16'(BG));
      vif.color_in = WHITE;
      vif.de_in = 1'b0;
      tick(4);
      check_eq("blank_rgb", 16'(vif.rgb), 16'h0);

      // Blink with BLINK_FRAMES=2, starting from a clean counter
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      vif.de_in = 1'b1;
      vif.blink_in = 1'b1;
      tick(4);
      check_eq("blink_f0", 16'(vif.rgb), 16'(WHITE));
      for (int f = 1; f < 8; f++) begin
         vif.vsync_in = 1'b1;
         tick(1);
         vif.vsync_in = 1'b0;
         tick(4);
         check_eq($sformatf("blink_f%0d", f), 16'(vif.rgb),
                  16'((((f / 2) % 2) == 0) ? WHITE : BG));
         if (f == 2) begin
            vif.blink_in = 1'b0;
            tick(4);
            check_eq("noblink_f2", 16'(vif.rgb), 16'(WHITE));
            vif.blink_in = 1'b1;
            tick(4);
         end
      end

      // Reset mid-frame while the blink phase is hidden
      reset = 1'b1;
      #1;
      check_eq("mid_rst_rgb", 16'(vif.rgb), 16'h0);
      check_eq("mid_rst_de", 16'(vif.de), 16'h0);
      check_eq("mid_rst_addr", 16'(vif.font_addr), 16'h0);
      tick(2);
      reset = 1'b0;
      tick(2);
      check_eq("refill_2", 16'(vif.rgb), 16'h0);
      tick(1);
      check_eq("refill_3", 16'(vif.rgb), 16'(WHITE));
      check_eq("refill_de", 16'(vif.de), 16'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
